// File: rtl/mac_seq_pkg.sv
// mac_seq_pkg
// Shared definitions for the MAC sequencer: parameter defaults, fixed
// output-port widths, a helper that derives counter widths from counts,
// and the sequencer state enum.
// No ports (package).

package mac_seq_pkg;

  // Layer-geometry defaults: 4 input chunks of 10 channels, 5 output groups
  // of 16 channels, a 32x32 feature map, 10-cycle MAC pipeline.
  localparam int DATA_CHUNKS_DEF = 4;
  localparam int OC_GROUPS_DEF   = 5;
  localparam int PIXELS_DEF      = 1024;
  localparam int PIPE_LAT_DEF    = 10;

  // Widths of the externally visible address and index ports.
  localparam int FMAP_ADDR_W  = 12;
  localparam int PARAM_ADDR_W = 5;
  localparam int PIX_W        = 10;
  localparam int GRP_W        = 3;

  // Bits needed to count 0..n-1; never less than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int C_W_DEF = cnt_width(DATA_CHUNKS_DEF);
  localparam int R_W_DEF = cnt_width(OC_GROUPS_DEF);
  localparam int P_W_DEF = cnt_width(PIXELS_DEF);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/mac_seq_delay_line.sv
// mac_seq_delay_line
// DEPTH-stage shift register carrying {valid, last_chunk, pixel, group}
// alongside the MAC pipeline so results can be tagged at the data_out tap.
// A new entry is shifted in every cycle; idle cycles enter as valid=0.
// Ports:
//   clk, rstn      clock, asynchronous active-low reset
//   flush          clears every valid bit at the next edge
//   in_valid/in_last/in_pix/in_grp   entry for stage 0
//   tap_valid/tap_last/tap_pix/tap_grp  last stage
//   any_valid      some stage holds a valid entry

module mac_seq_delay_line #(
  parameter int DEPTH = 10,
  parameter int P_W   = 10,
  parameter int R_W   = 3
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           flush,
  input  logic           in_valid,
  input  logic           in_last,
  input  logic [P_W-1:0] in_pix,
  input  logic [R_W-1:0] in_grp,
  output logic           tap_valid,
  output logic           tap_last,
  output logic [P_W-1:0] tap_pix,
  output logic [R_W-1:0] tap_grp,
  output logic           any_valid
);

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] last_q, last_d;
  logic [P_W-1:0]   pix_q [DEPTH];
  logic [P_W-1:0]   pix_d [DEPTH];
  logic [R_W-1:0]   grp_q [DEPTH];
  logic [R_W-1:0]   grp_d [DEPTH];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        assign valid_d[gi] = in_valid & ~flush;
        assign last_d[gi]  = in_last;
        assign pix_d[gi]   = in_pix;
        assign grp_d[gi]   = in_grp;
      end else begin : g_body
        assign valid_d[gi] = valid_q[gi-1] & ~flush;
        assign last_d[gi]  = last_q[gi-1];
        assign pix_d[gi]   = pix_q[gi-1];
        assign grp_d[gi]   = grp_q[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q <= '0;
      last_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pix_q[i] <= '0;
        grp_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      last_q  <= last_d;
      pix_q   <= pix_d;
      grp_q   <= grp_d;
    end
  end

  assign tap_valid = valid_q[DEPTH-1];
  assign tap_last  = last_q[DEPTH-1];
  assign tap_pix   = pix_q[DEPTH-1];
  assign tap_grp   = grp_q[DEPTH-1];
  assign any_valid = |valid_q;

endmodule

// File: rtl/mac_sequencer.sv
// mac_sequencer
// Walks one convolution layer pass through a MAC: for every pixel, every
// output-channel group, every input chunk it issues an fmap/parameter
// address pair with mac_in_valid, then tags finished results PIPE_LAT
// cycles later at the MAC output.
// Optional feature: define MAC_SEQ_PERF_EN to add perf_stall_cycles.
// Ports:
//   clk, rstn         clock, asynchronous active-low reset
//   start, abort      launch a pass / cancel it (abort has priority)
//   fmap_rdy          fmap buffer can supply the addressed word
//   busy, done        pass in progress / one-cycle completion pulse
//   fmap_addr         pixel*DATA_CHUNKS + chunk
//   param_addr        group*DATA_CHUNKS + chunk
//   mac_in_valid      issue beat to the MAC
//   adder_rst         accumulator clear, coincides with out_valid
//   out_valid/out_pix/out_grp  finished 16-channel result and its tag
//   perf_stall_cycles (MAC_SEQ_PERF_EN) RUN cycles spent waiting on fmap

module mac_sequencer
  import mac_seq_pkg::*;
#(
  parameter int DATA_CHUNKS = DATA_CHUNKS_DEF,
  parameter int OC_GROUPS   = OC_GROUPS_DEF,
  parameter int PIXELS      = PIXELS_DEF,
  parameter int PIPE_LAT    = PIPE_LAT_DEF
) (
  input  logic                    clk,
`ifdef MAC_SEQ_PERF_EN
  output logic [31:0]             perf_stall_cycles,
`endif
  input  logic                    rstn,
  input  logic                    start,
  input  logic                    abort,
  input  logic                    fmap_rdy,
  output logic                    busy,
  output logic                    done,
  output logic [FMAP_ADDR_W-1:0]  fmap_addr,
  output logic [PARAM_ADDR_W-1:0] param_addr,
  output logic                    mac_in_valid,
  output logic                    adder_rst,
  output logic                    out_valid,
  output logic [PIX_W-1:0]        out_pix,
  output logic [GRP_W-1:0]        out_grp
);

  localparam int C_W = cnt_width(DATA_CHUNKS);
  localparam int R_W = cnt_width(OC_GROUPS);
  localparam int P_W = cnt_width(PIXELS);

  localparam logic [C_W-1:0] C_MAX = C_W'(DATA_CHUNKS - 1);
  localparam logic [R_W-1:0] R_MAX = R_W'(OC_GROUPS - 1);
  localparam logic [P_W-1:0] P_MAX = P_W'(PIXELS - 1);

  state_e         state_q, state_d;
  logic [C_W-1:0] c_q, c_d;
  logic [R_W-1:0] r_q, r_d;
  logic [P_W-1:0] p_q, p_d;

  logic issue, last_c, last_r, last_p, flush, any_valid;
  logic tap_valid, tap_last;
  logic [P_W-1:0] tap_pix;
  logic [R_W-1:0] tap_grp;

  assign issue  = (state_q == RUN) && fmap_rdy;
  assign last_c = (c_q == C_MAX);
  assign last_r = (r_q == R_MAX);
  assign last_p = (p_q == P_MAX);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      c_q     <= '0;
      r_q     <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      r_q     <= r_d;
      p_q     <= p_d;
    end
  end

  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    r_d     = r_q;
    p_d     = p_q;
    flush   = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d = RUN;
          c_d     = '0;
          r_d     = '0;
          p_d     = '0;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
          c_d     = '0;
          r_d     = '0;
          p_d     = '0;
          flush   = 1'b1;
        end else if (issue) begin
          // Nested odometer: chunk innermost, then group, then pixel.
          c_d = last_c ? '0 : c_q + C_W'(1);
          if (last_c) begin
            r_d = last_r ? '0 : r_q + R_W'(1);
            if (last_r) begin
              p_d = last_p ? '0 : p_q + P_W'(1);
            end
          end
          if (last_c && last_r && last_p) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (abort) begin
          state_d = IDLE;
          c_d     = '0;
          r_d     = '0;
          p_d     = '0;
          flush   = 1'b1;
        end else if (!any_valid) begin
          // Pipeline has emptied: the final result left the tap last cycle.
          state_d = IDLE;
          done    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy         = (state_q != IDLE);
  assign mac_in_valid = issue;
  assign fmap_addr    = FMAP_ADDR_W'(p_q) * FMAP_ADDR_W'(DATA_CHUNKS) + FMAP_ADDR_W'(c_q);
  assign param_addr   = PARAM_ADDR_W'(r_q) * PARAM_ADDR_W'(DATA_CHUNKS) + PARAM_ADDR_W'(c_q);

  mac_seq_delay_line #(
    .DEPTH (PIPE_LAT),
    .P_W   (P_W),
    .R_W   (R_W)
  ) u_delay (
    .clk       (clk),
    .rstn      (rstn),
    .flush     (flush),
    .in_valid  (issue),
    .in_last   (last_c),
    .in_pix    (p_q),
    .in_grp    (r_q),
    .tap_valid (tap_valid),
    .tap_last  (tap_last),
    .tap_pix   (tap_pix),
    .tap_grp   (tap_grp),
    .any_valid (any_valid)
  );

  // A result is complete only when its final input chunk reaches the tap.
  assign out_valid = tap_valid && tap_last;
  assign adder_rst = out_valid;
  assign out_pix   = PIX_W'(tap_pix);
  assign out_grp   = GRP_W'(tap_grp);

`ifdef MAC_SEQ_PERF_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (state_q == IDLE && start && !abort) begin
      stall_d = '0;
    end else if (state_q == RUN && !fmap_rdy && stall_q != '1) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign perf_stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_mac_sequencer.sv
// tb_mac_sequencer
// Scoreboard bench: a behavioural model of the pass order predicts each
// issue beat; finished results are queued with their due cycle and popped
// when the design's tap is expected to report them.

module tb_mac_sequencer;

  localparam int DC = 4;
  localparam int OG = 5;
  localparam int PX = 1024;
  localparam int PL = 10;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        fmap_rdy = 1'b0;
  logic        busy, done, mac_in_valid, adder_rst, out_valid;
  logic [11:0] fmap_addr;
  logic [4:0]  param_addr;
  logic [9:0]  out_pix;
  logic [2:0]  out_grp;
`ifdef MAC_SEQ_PERF_EN
  logic [31:0] perf_stall_cycles;
`endif

  always #5 clk = ~clk;

  mac_sequencer dut (
    .clk               (clk),
`ifdef MAC_SEQ_PERF_EN
    .perf_stall_cycles (perf_stall_cycles),
`endif
    .rstn              (rstn),
    .start             (start),
    .abort             (abort),
    .fmap_rdy          (fmap_rdy),
    .busy              (busy),
    .done              (done),
    .fmap_addr         (fmap_addr),
    .param_addr        (param_addr),
    .mac_in_valid      (mac_in_valid),
    .adder_rst         (adder_rst),
    .out_valid         (out_valid),
    .out_pix           (out_pix),
    .out_grp           (out_grp)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s got %0d expected %0d", tag, obs, exp);
  endtask

  typedef struct {
    int pix;
    int grp;
    int due;
  } exp_t;
  exp_t sb[$];

  // Model state: 0 idle, 1 run, 2 drain.
  int m_state = 0;
  int m_p = 0, m_r = 0, m_c = 0;
  int cyc = 0;
  int n_beats, n_ov, n_done;
  int first_ov_cyc, last_ov_cyc, done_cyc, start_cyc, ov21_cyc;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic clear_stats();
    n_beats = 0; n_ov = 0; n_done = 0;
    first_ov_cyc = -1; last_ov_cyc = -1; done_cyc = -1; ov21_cyc = -1;
  endtask

  always @(negedge clk) begin
    if (!rstn) begin
      check_val("rst_busy", busy, 0);
      check_val("rst_done", done, 0);
      check_val("rst_miv", mac_in_valid, 0);
      check_val("rst_ov", out_valid, 0);
      check_val("rst_arst", adder_rst, 0);
      check_val("rst_faddr", fmap_addr, 0);
      check_val("rst_paddr", param_addr, 0);
      check_val("rst_pix", out_pix, 0);
      check_val("rst_grp", out_grp, 0);
      m_state = 0; m_p = 0; m_r = 0; m_c = 0;
      sb.delete();
    end else begin
      automatic logic exp_issue = (m_state == 1) && fmap_rdy;
      automatic logic exp_done  = (m_state == 2) && (sb.size() == 0) && !abort;
      automatic logic exp_ov    = (sb.size() > 0) && (sb[0].due == cyc);
      check_val("mac_in_valid", mac_in_valid, exp_issue);
      check_val("busy", busy, m_state != 0);
      check_val("done", done, exp_done);
      check_val("out_valid", out_valid, exp_ov);
      check_val("adder_rst", adder_rst, exp_ov);
      if (m_state == 1) begin
        check_val("fmap_addr", fmap_addr, m_p * DC + m_c);
        check_val("param_addr", param_addr, m_r * DC + m_c);
      end
      if (exp_ov) begin
        check_val("out_pix", out_pix, sb[0].pix);
        check_val("out_grp", out_grp, sb[0].grp);
        if (sb[0].pix == 2 && sb[0].grp == 1) ov21_cyc = cyc;
        void'(sb.pop_front());
      end
      if (mac_in_valid) n_beats++;
      if (out_valid) begin
        if (first_ov_cyc < 0) first_ov_cyc = cyc;
        last_ov_cyc = cyc;
        n_ov++;
      end
      if (done) begin
        n_done++;
        done_cyc = cyc;
      end
      // Next-cycle model state.
      if (abort && m_state != 0) begin
        m_state = 0; m_p = 0; m_r = 0; m_c = 0;
        sb.delete();
      end else if (m_state == 0 && start && !abort) begin
        m_state = 1; m_p = 0; m_r = 0; m_c = 0;
        start_cyc = cyc;
      end else if (exp_issue) begin
        if (m_c == DC - 1) sb.push_back('{pix: m_p, grp: m_r, due: cyc + PL});
        if (m_c == DC - 1 && m_r == OG - 1 && m_p == PX - 1) m_state = 2;
        m_c++;
        if (m_c == DC) begin
          m_c = 0; m_r++;
          if (m_r == OG) begin
            m_r = 0; m_p++;
            if (m_p == PX) m_p = 0;
          end
        end
      end else if (exp_done) begin
        m_state = 0;
      end
    end
  end

  task automatic wait_state(input int st, input int lim, input string tag);
    int ok = 0;
    for (int i = 0; i < lim; i++) begin
      if (m_state == st) begin
        ok = 1;
        break;
      end
      @(posedge clk); #1;
    end
    check_val(tag, ok, 1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  initial begin
    int p1_ov21, snap_ov, snap_done, found;
    clear_stats();
    #2 rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    @(posedge clk); #1;

    // Pass 1: uninterrupted, with stray starts in RUN and DRAIN.
    fmap_rdy = 1'b1;
    clear_stats();
    pulse_start();
    repeat (100) @(posedge clk);
    #1 pulse_start();
    wait_state(2, 25000, "tmo_drain1");
    pulse_start();
    wait_state(0, 100, "tmo_idle1");
    repeat (5) @(posedge clk);
    #1;
    check_val("p1_beats", n_beats, DC * OG * PX);
    check_val("p1_outs", n_ov, OG * PX);
    check_val("p1_done_cnt", n_done, 1);
    check_val("p1_first_lat", first_ov_cyc - start_cyc, DC + PL);
    check_val("p1_done_lat", done_cyc - last_ov_cyc, 1);
    check_val("p1_busy_end", busy, 0);
`ifdef MAC_SEQ_PERF_EN
    check_val("p1_perf", perf_stall_cycles, 0);
`endif
    p1_ov21 = ov21_cyc - start_cyc;
    $display("pass1 beats=%0d outs=%0d done=%0d", n_beats, n_ov, n_done);

    // Pass 2: 7-cycle fmap stall at p=2 r=1 c=2, then reset during DRAIN.
    clear_stats();
    pulse_start();
    found = 0;
    for (int i = 0; i < 2000; i++) begin
      if (m_state == 1 && m_p == 2 && m_r == 1 && m_c == 2) begin
        found = 1;
        break;
      end
      @(posedge clk); #1;
    end
    check_val("tmo_stall_pt", found, 1);
    fmap_rdy = 1'b0;
    repeat (7) begin
      #1;
      check_val("stall_faddr", fmap_addr, 2 * DC + 2);
      check_val("stall_paddr", param_addr, 1 * DC + 2);
      check_val("stall_miv", mac_in_valid, 0);
      @(posedge clk); #1;
    end
    fmap_rdy = 1'b1;
`ifdef MAC_SEQ_PERF_EN
    check_val("p2_perf", perf_stall_cycles, 7);
`endif
    wait_state(2, 25000, "tmo_drain2");
    check_val("stall_late", (ov21_cyc - start_cyc) - p1_ov21, 7);
    $display("pass2 stall result delay=%0d", (ov21_cyc - start_cyc) - p1_ov21);
    repeat (3) @(posedge clk);
    #1 rstn = 1'b0;
    #1;
    check_val("drst_busy", busy, 0);
    check_val("drst_ov", out_valid, 0);
    check_val("drst_done", done, 0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    snap_ov = n_ov;
    snap_done = n_done;
    repeat (30) @(posedge clk);
    #1;
    check_val("drst_no_ov", n_ov, snap_ov);
    check_val("drst_no_done", n_done, snap_done);
`ifdef MAC_SEQ_PERF_EN
    check_val("drst_perf", perf_stall_cycles, 0);
`endif
    $display("reset-in-drain outs_after=%0d done_after=%0d", n_ov - snap_ov, n_done - snap_done);

    // Abort at p=5, with start asserted alongside it.
    clear_stats();
    pulse_start();
    found = 0;
    for (int i = 0; i < 2000; i++) begin
      if (m_state == 1 && m_p == 5) begin
        found = 1;
        break;
      end
      @(posedge clk); #1;
    end
    check_val("tmo_abort_pt", found, 1);
    abort = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    start = 1'b0;
    check_val("abort_busy", busy, 0);
    snap_ov = n_ov;
    snap_done = n_done;
    repeat (30) @(posedge clk);
    #1;
    check_val("abort_no_ov", n_ov, snap_ov);
    check_val("abort_no_done", n_done, snap_done);
    $display("abort outs_after=%0d done_after=%0d", n_ov - snap_ov, n_done - snap_done);

    // start and abort together in IDLE: stays idle.
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    check_val("start_abort_idle", busy, 0);

    // Restart from zero.
    pulse_start();
    #1;
    check_val("restart_faddr", fmap_addr, 0);
    check_val("restart_miv", mac_in_valid, 1);
    repeat (20) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    check_val("final_busy", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mac_sequencer.md
MAC_SEQUENCER -- requirements
Module: mac_sequencer

Interface
REQ-001 Parameters (name, default, meaning): DATA_CHUNKS, 4, 80-bit input-channel chunks per pixel (4x10 = 40 channels).
REQ-002 OC_GROUPS, 5, output-channel groups of 16 per pixel (80 channels).
REQ-003 PIXELS, 1024, feature-map pixels (32x32).
REQ-004 PIPE_LAT, 10, MAC cycles from input beat to the data_out tap.
REQ-005 Ports (name, direction, width, meaning):
- clk, in, 1, sole clock, rising edge.
- rstn, in, 1, asynchronous active-low reset.
- start, in, 1, launch one full layer pass.
- abort, in, 1, synchronous cancel.
- fmap_rdy, in, 1, fmap buffer can supply the addressed word this cycle.
- busy, out, 1, high from the start accept until done.
- done, out, 1, one-cycle completion pulse.
- fmap_addr, out, 12, fmap chunk address.
- param_addr, out, 5, parameter bank word address.
- mac_in_valid, out, 1, drives MAC data and param valid.
- adder_rst, out, 1, accumulator clear to the MAC.
- out_valid, out, 1, MAC data_out holds a finished 16-channel result.
- out_pix, out, 10, pixel index of that result.
- out_grp, out, 3, output-channel group of that result.

Function
REQ-006 The FSM shall have states IDLE, RUN, DRAIN.
REQ-007 IDLE->RUN on start; start shall be ignored in RUN and DRAIN.
REQ-008 Issue beat = RUN && fmap_rdy; mac_in_valid shall equal the issue beat.
REQ-009 Counters: chunk c (innermost, 0..DATA_CHUNKS-1), group r (0..OC_GROUPS-1), pixel p (outermost).
REQ-010 Counters shall advance only on issue beats; each wraps to 0 and carries to the next counter when at max.
REQ-011 Combinational from counters: fmap_addr = p*DATA_CHUNKS + c; param_addr = r*DATA_CHUNKS + c.
REQ-012 While fmap_rdy is low, counters and addresses shall hold and mac_in_valid shall be 0.
REQ-013 The issue beat with p, r, c all at max shall move RUN->DRAIN.
REQ-014 A PIPE_LAT-deep delay line shall carry {valid, last_chunk, p, r} per cycle; bubbles enter as valid=0.
REQ-015 At the tap: out_valid = valid && last_chunk; adder_rst = out_valid; out_pix and out_grp from the tap.
REQ-016 out_valid shall follow the chunk-(DATA_CHUNKS-1) issue beat by exactly PIPE_LAT cycles.
REQ-017 DRAIN->IDLE when the delay line holds no valid entry; done pulses that cycle; busy falls the next cycle.
REQ-018 abort in RUN or DRAIN shall, next edge: go to IDLE, clear counters and all delay-line valid bits, give no done, drop busy.
REQ-019 abort and start in the same cycle: abort wins.
REQ-020 A start accepted in IDLE restarts at p=r=c=0.

Reset
REQ-021 rstn low shall asynchronously force IDLE, all counters and the delay line to 0, and all outputs to 0.
REQ-022 Reset mid-pass shall discard the pass; no out_valid or done shall follow.

Configuration
REQ-023 With MAC_SEQ_PERF_EN defined: output perf_stall_cycles (32 bits), counting RUN cycles with fmap_rdy low, cleared on start accept and on reset, saturating at max.
REQ-024 Without MAC_SEQ_PERF_EN: neither the port nor the counter shall exist.

Structure
REQ-025 Package mac_seq_pkg shall hold the parameter defaults, derived counter widths and the state enum.
REQ-026 Sub-module mac_seq_delay_line shall hold the PIPE_LAT-stage {valid, last_chunk, p, r} shift register with flush input.

Verification
REQ-027 Reset release, start, fmap_rdy=1: fmap_addr 0,1,2,3,0,1,2,3... and param_addr 0..19 for p=0; then fmap_addr 4.
REQ-028 Same run: 20480 mac_in_valid beats, 5120 out_valid pulses, first at PIPE_LAT cycles after beat 4; done 1 cycle after the last out_valid tap cycle; out_pix/out_grp ordered (0,0)..(1023,4).
REQ-029 fmap_rdy low 7 cycles at p=2, r=1, c=2: addresses hold 7 cycles, mac_in_valid low 7 cycles, that result's out_valid 7 cycles late; perf_stall_cycles=7 with MAC_SEQ_PERF_EN.
REQ-030 abort at p=5 in RUN: idle next cycle, busy=0, no further out_valid, no done; a new start issues fmap_addr 0.
REQ-031 start pulsed during RUN and during DRAIN: no restart; single done.
REQ-032 rstn low during DRAIN: all outputs 0 immediately; no done after release.
